// File: rtl/eth_fcs_framer.sv
// Ethernet TX framer: forwards payload, zero-pads short frames and appends the CRC-32 FCS.
// Optional feature macro: ETH_FCS_PAD_EN (defined = pad short payloads up to MIN_PAYLOAD).
module eth_fcs_framer #(
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic [47:0] in_dest_mac,
  input  logic [47:0] in_src_mac,
  input  logic [15:0] in_ether_type,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        out_in_ready,
  output logic [7:0]  out_eth_frame,
  output logic        out_frame_en,
  output logic        out_last,
  input  logic        in_tx_ready,
  output logic        out_oversize
);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
`ifdef ETH_FCS_PAD_EN
  localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
`endif

  // Marker block that only elaborates for an unusable parameter pair.
  if (MIN_PAYLOAD > MAX_PAYLOAD) begin : g_min_exceeds_max
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_DISCARD = 3'd3,
`ifdef ETH_FCS_PAD_EN
    S_PAD     = 3'd4,
`endif
    S_FCS     = 3'd5
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [111:0] r_hdr;
  logic [3:0]   r_hdr_cnt;
  logic [31:0]  r_crc;
  logic [10:0]  r_cnt;
  logic [1:0]   r_fcs_idx;
  logic [7:0]   r_out_data;
  logic         r_out_en;
  logic         r_out_last;
  logic         r_oversize;

  logic         w_out_free;
  logic [10:0]  w_cnt_inc;
  logic [31:0]  w_crc_inv;
  logic [7:0]   w_fcs_byte;
  logic [31:0]  w_crc_next;
  logic         w_in_ready;
  logic         w_start;
  logic         w_hdr_shift;
  logic         w_crc_en;
  logic [7:0]   w_crc_byte;
  logic         w_load;
  logic [7:0]   w_load_data;
  logic         w_load_last;
  logic         w_cnt_en;
  logic         w_fcs_adv;
  logic         w_oversize_set;

  // Reflected CRC-32, one byte per call, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign w_out_free = !r_out_en || in_tx_ready;
  assign w_cnt_inc  = r_cnt + 11'd1;
  assign w_crc_inv  = ~r_crc;
  assign w_fcs_byte = w_crc_inv[{r_fcs_idx, 3'b000} +: 8];
  assign w_crc_next = crc32_byte(r_crc, w_crc_byte);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_in_ready     = 1'b0;
    w_start        = 1'b0;
    w_hdr_shift    = 1'b0;
    w_crc_en       = 1'b0;
    w_crc_byte     = 8'h00;
    w_load         = 1'b0;
    w_load_data    = 8'h00;
    w_load_last    = 1'b0;
    w_cnt_en       = 1'b0;
    w_fcs_adv      = 1'b0;
    w_oversize_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_start      = 1'b1;
          w_state_next = S_HDR;
        end
      end
      S_HDR: begin
        w_crc_en    = 1'b1;
        w_crc_byte  = r_hdr[111:104];
        w_hdr_shift = 1'b1;
        if (r_hdr_cnt == 4'd13) begin
          w_state_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        w_in_ready = w_out_free;
        if (in_valid && w_out_free) begin
          w_crc_en    = 1'b1;
          w_crc_byte  = in_data;
          w_load      = 1'b1;
          w_load_data = in_data;
          w_cnt_en    = 1'b1;
          if (in_last) begin
`ifdef ETH_FCS_PAD_EN
            w_state_next = (w_cnt_inc < MIN_CNT) ? S_PAD : S_FCS;
`else
            w_state_next = S_FCS;
`endif
          end else if (w_cnt_inc == MAX_CNT) begin
            w_state_next   = S_DISCARD;
            w_oversize_set = 1'b1;
          end
        end
      end
      S_DISCARD: begin
        w_in_ready = 1'b1;
        if (in_valid && in_last) begin
          w_state_next = S_FCS;
        end
      end
`ifdef ETH_FCS_PAD_EN
      S_PAD: begin
        if (w_out_free) begin
          w_crc_en    = 1'b1;
          w_crc_byte  = 8'h00;
          w_load      = 1'b1;
          w_load_data = 8'h00;
          w_cnt_en    = 1'b1;
          if (w_cnt_inc >= MIN_CNT) begin
            w_state_next = S_FCS;
          end
        end
      end
`endif
      S_FCS: begin
        // The register is free once the previous byte leaves; the 4th FCS byte ends the frame.
        if (w_out_free) begin
          if (r_out_en && r_out_last) begin
            w_state_next = S_IDLE;
          end else begin
            w_load      = 1'b1;
            w_load_data = w_fcs_byte;
            w_load_last = (r_fcs_idx == 2'd3);
            w_fcs_adv   = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_hdr      <= '0;
      r_hdr_cnt  <= 4'd0;
      r_crc      <= CRC_INIT;
      r_cnt      <= 11'd0;
      r_fcs_idx  <= 2'd0;
      r_out_data <= 8'h00;
      r_out_en   <= 1'b0;
      r_out_last <= 1'b0;
      r_oversize <= 1'b0;
    end else begin
      if (w_start) begin
        r_hdr     <= {in_dest_mac, in_src_mac, in_ether_type};
        r_hdr_cnt <= 4'd0;
        r_crc     <= CRC_INIT;
        r_cnt     <= 11'd0;
        r_fcs_idx <= 2'd0;
      end
      if (w_hdr_shift) begin
        r_hdr     <= {r_hdr[103:0], 8'h00};
        r_hdr_cnt <= r_hdr_cnt + 4'd1;
      end
      if (w_crc_en) begin
        r_crc <= w_crc_next;
      end
      if (w_cnt_en) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_fcs_adv) begin
        r_fcs_idx <= r_fcs_idx + 2'd1;
      end
      if (w_load) begin
        r_out_data <= w_load_data;
        r_out_en   <= 1'b1;
        r_out_last <= w_load_last;
      end else if (r_out_en && in_tx_ready) begin
        r_out_en   <= 1'b0;
        r_out_last <= 1'b0;
      end
      r_oversize <= w_oversize_set;
    end
  end

  assign out_in_ready  = w_in_ready;
  assign out_eth_frame = r_out_data;
  assign out_frame_en  = r_out_en;
  assign out_last      = r_out_last;
  assign out_oversize  = r_oversize;

endmodule

// File: tb/tb_eth_fcs_framer.sv
// Directed bench for eth_fcs_framer: long, short, stalled, oversize, reset and back-to-back frames.
module tb_eth_fcs_framer;

  localparam int MIN_P = 46;
  localparam int MAX_P = 64;
`ifdef ETH_FCS_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam logic [111:0] HDR_A = {48'h001122334455, 48'h02AABBCCDDEE, 16'h0800};
  localparam logic [111:0] HDR_B = {48'hFFFFFFFFFFFF, 48'h0A0B0C0D0E0F, 16'h88B5};

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] dest_mac, src_mac;
  logic [15:0] ether_type;
  logic [7:0]  data;
  logic        valid, last, tx_ready;
  logic        in_ready, frame_en, out_last_w, oversize;
  logic [7:0]  frame_byte;

  eth_fcs_framer #(.MIN_PAYLOAD(MIN_P), .MAX_PAYLOAD(MAX_P)) dut (
    .in_clk        (clk),
    .in_rst        (rst),
    .in_dest_mac   (dest_mac),
    .in_src_mac    (src_mac),
    .in_ether_type (ether_type),
    .in_data       (data),
    .in_valid      (valid),
    .in_last       (last),
    .out_in_ready  (in_ready),
    .out_eth_frame (frame_byte),
    .out_frame_en  (frame_en),
    .out_last      (out_last_w),
    .in_tx_ready   (tx_ready),
    .out_oversize  (oversize)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] long_ref[$];
  int g_ovs, g_hold_err, g_first_rdy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_hdr(input logic [111:0] hdr);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 14; k++) c = crc_byte(c, hdr[111 - 8*k -: 8]);
    return c;
  endfunction

  task automatic run_frame(input string name, input int len, input logic [7:0] base,
                           input logic [111:0] hdr, input bit rand_rdy,
                           input bit chain, input logic [111:0] next_hdr, input logic [7:0] next_base);
    int in_idx = 0;
    int cyc = 0;
    bit done = 1'b0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_b = 8'h00;
    logic prev_l = 1'b0;
    rx_q.delete();
    g_ovs = 0; g_hold_err = 0; g_first_rdy = -1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      {dest_mac, src_mac, ether_type} = hdr;
      tx_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (in_idx < len) begin
        valid = 1'b1; data = base + 8'(in_idx); last = (in_idx == len - 1);
      end else begin
        valid = 1'b0; data = 8'h00; last = 1'b0;
      end
      #1;
      if (oversize) g_ovs++;
      if (prev_stall && (!frame_en || frame_byte !== prev_b || out_last_w !== prev_l)) g_hold_err++;
      prev_stall = frame_en && !tx_ready;
      prev_b = frame_byte;
      prev_l = out_last_w;
      if (in_ready && g_first_rdy < 0) g_first_rdy = cyc;
      if (valid && in_ready) in_idx++;
      if (frame_en && tx_ready) begin
        rx_q.push_back(frame_byte);
        if (out_last_w) done = 1'b1;
      end
      if (done && chain) begin
        {dest_mac, src_mac, ether_type} = next_hdr;
        valid = 1'b1; data = next_base; last = 1'b0;
      end
      cyc++;
    end
    check_eq({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic verify(input string name, input int len, input logic [7:0] base,
                        input logic [111:0] hdr, input int exp_beats, input int exp_ovs);
    logic [7:0] exp_q[$];
    logic [31:0] c;
    logic [31:0] got_fcs;
    int fwd, mism, n;
    fwd = (len > MAX_P) ? MAX_P : len;
    for (int i = 0; i < fwd; i++) exp_q.push_back(base + 8'(i));
    if (PAD) while (exp_q.size() < MIN_P) exp_q.push_back(8'h00);
    c = crc_hdr(hdr);
    foreach (exp_q[i]) c = crc_byte(c, exp_q[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    check_eq({name, "_beats"}, 32'(rx_q.size()), 32'(exp_beats));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    mism = (rx_q.size() > exp_q.size()) ? rx_q.size() - exp_q.size() : exp_q.size() - rx_q.size();
    for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) mism++;
    check_eq({name, "_bytes"}, 32'(mism), 32'd0);
    got_fcs = 32'd0;
    if (rx_q.size() >= 4)
      got_fcs = {rx_q[rx_q.size()-1], rx_q[rx_q.size()-2], rx_q[rx_q.size()-3], rx_q[rx_q.size()-4]};
    check_eq({name, "_fcs"}, got_fcs, c);
    c = crc_hdr(hdr);
    foreach (rx_q[i]) c = crc_byte(c, rx_q[i]);
    check_eq({name, "_residue"}, c, 32'hDEBB20E3);
    check_eq({name, "_oversize"}, 32'(g_ovs), 32'(exp_ovs));
    check_eq({name, "_hold"}, 32'(g_hold_err), 32'd0);
    check_eq({name, "_rdy_lat"}, 32'(g_first_rdy), 32'd15);
    $display("frame %s: len=%0d beats=%0d fcs=0x%08h", name, len, rx_q.size(), got_fcs);
  endtask

  initial begin
    int mism;
    rst = 1'b1; valid = 1'b0; last = 1'b0; data = 8'h00; tx_ready = 1'b1;
    {dest_mac, src_mac, ether_type} = HDR_A;
    repeat (3) @(negedge clk);
    check_eq("rst_en", 32'(frame_en), 32'd0);
    check_eq("rst_rdy", 32'(in_ready), 32'd0);
    check_eq("rst_data", 32'(frame_byte), 32'd0);
    check_eq("rst_last", 32'(out_last_w), 32'd0);
    check_eq("rst_ovs", 32'(oversize), 32'd0);
    rst = 1'b0;

    run_frame("long", 60, 8'h00, HDR_A, 1'b0, 1'b0, HDR_A, 8'h00);
    verify("long", 60, 8'h00, HDR_A, 64, 0);
    long_ref = rx_q;

    run_frame("short", 10, 8'h40, HDR_B, 1'b0, 1'b0, HDR_A, 8'h00);
    verify("short", 10, 8'h40, HDR_B, PAD ? 50 : 14, 0);

    run_frame("bp", 60, 8'h00, HDR_A, 1'b1, 1'b0, HDR_A, 8'h00);
    verify("bp", 60, 8'h00, HDR_A, 64, 0);
    mism = (rx_q.size() == long_ref.size()) ? 0 : 1;
    if (mism == 0) foreach (rx_q[i]) if (rx_q[i] !== long_ref[i]) mism++;
    check_eq("bp_same_as_long", 32'(mism), 32'd0);

    run_frame("oversize", 70, 8'h80, HDR_B, 1'b0, 1'b0, HDR_A, 8'h00);
    verify("oversize", 70, 8'h80, HDR_B, 68, 1);

    // Abort a frame ten bytes into its payload.
    @(negedge clk);
    {dest_mac, src_mac, ether_type} = HDR_B;
    tx_ready = 1'b1;
    for (int i = 0, k = 0; i < 25; i++) begin
      valid = 1'b1; data = 8'hC0 + 8'(k); last = 1'b0;
      #1;
      if (in_ready) k++;
      @(negedge clk);
    end
    check_eq("pre_rst_en", 32'(frame_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_en", 32'(frame_en), 32'd0);
    check_eq("midrst_rdy", 32'(in_ready), 32'd0);
    check_eq("midrst_data", 32'(frame_byte), 32'd0);
    check_eq("midrst_last", 32'(out_last_w), 32'd0);
    $display("reset mid-frame applied");
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;

    run_frame("after_rst", 46, 8'h10, HDR_A, 1'b0, 1'b0, HDR_A, 8'h00);
    verify("after_rst", 46, 8'h10, HDR_A, 50, 0);

    run_frame("b2b_1", 48, 8'h20, HDR_A, 1'b0, 1'b1, HDR_B, 8'h90);
    verify("b2b_1", 48, 8'h20, HDR_A, 52, 0);
    run_frame("b2b_2", 12, 8'h90, HDR_B, 1'b0, 1'b0, HDR_A, 8'h00);
    verify("b2b_2", 12, 8'h90, HDR_B, PAD ? 50 : 16, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eth_fcs_framer.md
# eth_fcs_framer

Upstream stage of the Ethernet transmit path. Accepts a payload byte stream plus the frame's header fields. Emits the payload, zero padding up to the minimum length, and the 4-byte CRC-32 FCS as the byte stream (`in_eth_frame`/`in_frame_en`) consumed by the MII transmitter. The FCS covers destination MAC, source MAC, EtherType and padded payload. The header bytes are folded into the CRC internally but not re-emitted, because the transmitter serialises the header itself.

## Interface
- `MIN_PAYLOAD`, default 46, minimum payload octets; shorter frames are padded.
- `MAX_PAYLOAD`, default 1500, maximum payload octets forwarded.
- `in_clk`  input  1  sole clock, rising edge.
- `in_rst`  input  1  asynchronous, active-high reset.
- `in_dest_mac`  input  48  destination MAC, sampled at frame start.
- `in_src_mac`  input  48  source MAC, sampled at frame start.
- `in_ether_type`  input  16  EtherType, sampled at frame start.
- `in_data`  input  8  payload byte.
- `in_valid`  input  1  `in_data` valid.
- `in_last`  input  1  marks the final payload byte.
- `out_in_ready`  output  1  payload byte accepted when `in_valid && out_in_ready`.
- `out_eth_frame`  output  8  outgoing byte (payload, pad or FCS).
- `out_frame_en`  output  1  `out_eth_frame` valid.
- `out_last`  output  1  high on the final FCS byte.
- `in_tx_ready`  input  1  transmitter accepts the byte when `out_frame_en && in_tx_ready`.
- `out_oversize`  output  1  one-cycle pulse: payload exceeded `MAX_PAYLOAD`.

## Operation
- **States:** IDLE, HDR, PAYLOAD, DISCARD, PAD, FCS.
- **IDLE:** `out_in_ready`=0.
  - When `in_valid`=1, latch the three header fields, set CRC to 0xFFFFFFFF and go to HDR.
  - The payload byte is held, not consumed.
- **HDR:** 14 cycles, `out_in_ready`=0.
  - One header byte folded into the CRC per cycle, in network order: `dest[47:40]` … `dest[7:0]`, `src[47:40]` … `src[7:0]`, `type[15:8]`, `type[7:0]`.
  - After the 14th byte, go to PAYLOAD.
- **PAYLOAD:**
  - `out_in_ready` = `!out_frame_en || in_tx_ready`.
  - Each accepted byte is registered to `out_eth_frame`, folded into the CRC, and the 11-bit payload count is incremented.
  - When `in_last` is accepted, go to PAD if count < `MIN_PAYLOAD`, else to FCS.
  - If count reaches `MAX_PAYLOAD` without `in_last`, pulse `out_oversize` and go to DISCARD.
- **DISCARD:** `out_in_ready`=1, bytes dropped, no CRC update. On `in_last`, go to FCS.
- **PAD:** emit 0x00 bytes, each folded into the CRC, until count = `MIN_PAYLOAD`, then go to FCS.
- **FCS:** emit `~crc` least-significant byte first: `[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`. `out_last` is high on the 4th byte; on its acceptance, go to IDLE.
- **CRC:** CRC-32, reflected polynomial 0xEDB88320, computed one byte per cycle, LSB-first within each byte.
- **Payload restriction:** zero-length payload is not supported; `in_last` always accompanies ≥1 byte.
- **Output stall:** output bytes are never dropped or duplicated. While `out_frame_en && !in_tx_ready`, `out_eth_frame` and `out_last` hold and state does not advance.
- **Reset** (asynchronous, any state): state IDLE, `out_eth_frame`=0x00, `out_frame_en`=0, `out_last`=0, `out_in_ready`=0, `out_oversize`=0, counters 0, CRC 0xFFFFFFFF. A partially emitted frame is abandoned and the next frame starts clean.

## Timing
- Frame start → first `out_in_ready`: 15 cycles (1 IDLE + 14 HDR).
- Input accept → `out_frame_en`: 1 cycle (registered output).
- With `in_tx_ready` held at 1: one output byte per cycle, no bubbles between payload, pad and FCS.
- First FCS byte is presented the cycle after the last payload or pad byte is accepted.
- **Back-to-back frames:** IDLE is entered on acceptance of the `out_last` byte. The next frame's header is sampled that cycle or later, never earlier.
- **`out_oversize`:** asserted exactly in the cycle the state enters DISCARD.

## Configuration
- **`ETH_FCS_PAD_EN`**
  - Defined: PAD state present; short payloads are zero-padded to `MIN_PAYLOAD` before the FCS.
  - Undefined: PAD state compiled out; after `in_last` the block always goes to FCS, so a short payload yields a runt frame whose FCS covers the unpadded bytes.

## Test plan
- **Long payload:** 60 bytes 0x00..0x3B, `in_tx_ready`=1 → 64 output beats (60 payload + 4 FCS), `out_last` on beat 64. A reference CRC-32 run over the 14 header bytes + 64 output bytes leaves residue register 0xDEBB20E3.
- **Short payload:** 10-byte payload, macro defined → 36 bytes of 0x00 after the payload, 50 beats total, FCS matches the model. Same payload with the macro undefined → 14 beats total.
- **Backpressure:** random 50% `in_tx_ready` on the 60-byte frame → byte sequence identical to the unstalled run; data holds while stalled.
- **Oversize:** `MAX_PAYLOAD`=64, 70-byte payload → 64 payload bytes forwarded, `out_oversize` pulses once, bytes 65-70 dropped, FCS computed over 64 bytes.
- **Reset mid-frame:** `in_rst` pulsed mid-PAYLOAD → all outputs at reset values in the same cycle. A following 46-byte frame then produces 50 correct beats.
- **Back-to-back:** two frames with `in_valid` held high between them → second header sampled no earlier than the cycle of the first frame's `out_last` acceptance; both FCS values correct.
